// File: rtl/dot_product_pkg.sv
// Shared defaults, FSM encoding and status payload for the dot-product operand loader.
package dot_product_pkg;

    localparam int unsigned DP_N       = 8;
    localparam int unsigned DP_LEN     = 4;
    localparam int unsigned DP_TIMEOUT = 16;
    localparam int unsigned CYC_W      = 8;

    typedef enum logic [1:0] {
        ST_LOAD   = 2'd0,
        ST_START  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_OUTPUT = 2'd3
    } state_t;

    typedef struct packed {
        logic [CYC_W-1:0] cycles;
        logic             error;
    } status_t;

endpackage

// File: rtl/dot_product_loader_if.sv
// Element input stream and result output handshake of the operand loader.
interface dot_product_loader_if
    import dot_product_pkg::*;
#(
    parameter int unsigned N = DP_N
);

    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_data;
    logic             out_valid;
    logic             out_ready;
    logic [4*N-1:0]   out_result;
    logic [CYC_W-1:0] out_cycles;
    logic             out_error;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_result, out_cycles, out_error
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_result, out_cycles, out_error
    );

endinterface

// File: rtl/dot_product_wait_timer.sv
// Counts engine WAIT cycles and flags the cycle in which the TIMEOUT budget is used up.
module dot_product_wait_timer
    import dot_product_pkg::*;
#(
    parameter int unsigned TIMEOUT = DP_TIMEOUT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             en,
    output logic [CYC_W-1:0] count,
    output logic             expired_c
);

    localparam logic [CYC_W:0] LIMIT = (CYC_W+1)'(TIMEOUT);

    // Expiry is judged on count+1 so the flag rises in the TIMEOUT-th WAIT cycle.
    assign expired_c = ({1'b0, count} + (CYC_W+1)'(1)) == LIMIT;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + CYC_W'(1);
        end
    end

endmodule

// File: rtl/dot_product_loader.sv
// Packs a serial element stream into flat operands, starts the engine and returns
// its result and latency (or a timeout) over a valid/ready handshake.
module dot_product_loader
    import dot_product_pkg::*;
#(
    parameter int unsigned N       = DP_N,
    parameter int unsigned LEN     = DP_LEN,
    parameter int unsigned TIMEOUT = DP_TIMEOUT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    dot_product_loader_if.slave   bus,
    output logic [LEN*N-1:0]      a_flat,
    output logic [LEN*N-1:0]      b_flat,
    output logic                  start,
    input  logic                  eng_done,
    input  logic [4*N-1:0]        eng_result
);

    localparam int unsigned FW    = LEN * N;
    localparam int unsigned RW    = 4 * N;
    localparam int unsigned IDX_W = (2 * LEN > 1) ? $clog2(2 * LEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(2 * LEN - 1);

    state_t           state, state_d;
    logic [IDX_W-1:0] idx, idx_d;
    logic [FW-1:0]    a_d, b_d;
    logic             start_d;
    logic             out_valid_q, out_valid_d;
    logic [RW-1:0]    result_q, result_d;
    status_t          status_q, status_d;

    logic             tmr_clear, tmr_en, tmr_expired_c;
    logic [CYC_W-1:0] tmr_count;

    dot_product_wait_timer #(.TIMEOUT(TIMEOUT)) u_wait_timer (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear     (tmr_clear),
        .en        (tmr_en),
        .count     (tmr_count),
        .expired_c (tmr_expired_c)
    );

    assign bus.in_ready   = (state == ST_LOAD);
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = result_q;
    assign bus.out_cycles = status_q.cycles;
    assign bus.out_error  = status_q.error;

    // Next-state and next-output logic.
    always_comb begin
        state_d   = state;
        idx_d     = idx;
        a_d       = a_flat;
        b_d       = b_flat;
        result_d  = result_q;
        status_d  = status_q;
        tmr_clear = 1'b0;
        tmr_en    = 1'b0;

        case (state)
            ST_LOAD: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < int'(LEN); i++) begin
                        if (idx == IDX_W'(i))       a_d[i*N +: N] = bus.in_data;
                        if (idx == IDX_W'(LEN + i)) b_d[i*N +: N] = bus.in_data;
                    end
                    if (idx == IDX_LAST) begin
                        idx_d   = '0;
                        state_d = ST_START;
                    end else begin
                        idx_d = idx + IDX_W'(1);
                    end
                end
            end
            ST_START: begin
                tmr_clear      = 1'b1;
                status_d.error = 1'b0;
                state_d        = ST_WAIT;
            end
            ST_WAIT: begin
                // A done in the expiry cycle still counts as a completion.
                if (eng_done) begin
                    result_d        = eng_result;
                    status_d.cycles = tmr_count + CYC_W'(1);
                    status_d.error  = 1'b0;
                    state_d         = ST_OUTPUT;
                end else if (tmr_expired_c) begin
                    result_d        = '0;
                    status_d.cycles = CYC_W'(TIMEOUT);
                    status_d.error  = 1'b1;
                    state_d         = ST_OUTPUT;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            ST_OUTPUT: begin
                if (bus.out_ready) state_d = ST_LOAD;
            end
            default: state_d = ST_LOAD;
        endcase

        start_d     = (state_d == ST_START);
        out_valid_d = (state_d == ST_OUTPUT);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_LOAD;
            idx         <= '0;
            a_flat      <= '0;
            b_flat      <= '0;
            start       <= 1'b0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            status_q    <= '0;
        end else begin
            state       <= state_d;
            idx         <= idx_d;
            a_flat      <= a_d;
            b_flat      <= b_d;
            start       <= start_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            status_q    <= status_d;
        end
    end

endmodule

// File: tb/tb_dot_product_loader.sv
// Scoreboard bench for dot_product_loader with a mock engine driven from the test tasks.
module tb_dot_product_loader;
    import dot_product_pkg::*;

    localparam int unsigned N = 8, LEN = 4, TIMEOUT = 16;
    localparam int unsigned FW = LEN * N, RW = 4 * N;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    dot_product_loader_if #(.N(N)) bif ();
    logic [FW-1:0] a_flat, b_flat;
    logic          start;
    logic          eng_done;
    logic [RW-1:0] eng_result;

    dot_product_loader #(.N(N), .LEN(LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bif),
        .a_flat     (a_flat),
        .b_flat     (b_flat),
        .start      (start),
        .eng_done   (eng_done),
        .eng_result (eng_result)
    );

    typedef struct {
        logic [RW-1:0] res;
        logic [7:0]    cyc;
        logic          err;
        logic [FW-1:0] a;
        logic [FW-1:0] b;
    } exp_t;

    exp_t sb[$];
    int vectors = 0;
    int miscompares = 0;

    // Edge-level monitor of accepts and start pulses (pre-edge values).
    int edge_n = 0, acc_cnt = 0, last_acc = -1, start_cnt = 0, start_edge = -1;
    always @(posedge clk) begin
        edge_n++;
        if (bif.in_valid && bif.in_ready) begin
            acc_cnt++;
            last_acc = edge_n;
        end
        if (start) begin
            start_cnt++;
            start_edge = edge_n;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog");
    end

    function automatic logic [RW-1:0] dot(input logic [FW-1:0] a, input logic [FW-1:0] b);
        logic [RW-1:0] s = '0;
        for (int i = 0; i < int'(LEN); i++) s += RW'(a[i*N +: N]) * RW'(b[i*N +: N]);
        return s;
    endfunction

    function automatic void push_exp(input logic [FW-1:0] a, input logic [FW-1:0] b,
                                     input logic [RW-1:0] res, input logic [7:0] cyc, input logic err);
        exp_t e;
        e.a = a; e.b = b; e.res = res; e.cyc = cyc; e.err = err;
        sb.push_back(e);
    endfunction

    task automatic send_word(input logic [N-1:0] d, input int gap);
        int n = 0;
        repeat (gap) @(negedge clk);
        bif.in_valid = 1'b1;
        bif.in_data  = d;
        while (!bif.in_ready && n < 100) begin @(negedge clk); n++; end
        if (!bif.in_ready) begin
            miscompares++;
            $display("FAIL send_word: in_ready stuck at %0b, required 1", bif.in_ready);
        end
        @(negedge clk);
        bif.in_valid = 1'b0;
        bif.in_data  = N'($urandom);
    endtask

    task automatic load_vec(input logic [FW-1:0] a, input logic [FW-1:0] b, input bit bubbles);
        for (int i = 0; i < 2 * int'(LEN); i++) begin
            int g;
            g = !bubbles ? 0 : (i % 3 == 0) ? 0 : (i % 3 == 1) ? 1 : 3;
            send_word((i < int'(LEN)) ? a[i*N +: N] : b[(i-int'(LEN))*N +: N], g);
        end
    endtask

    // Mock engine: waits for start, then pulses eng_done lat cycles later (lat 0 = never).
    task automatic engine(input int lat, input logic [RW-1:0] res);
        int n = 0;
        while (!start && n < 50) begin @(negedge clk); n++; end
        vectors++;
        if (!start) begin
            miscompares++;
            $display("FAIL engine_start: start=%0b, required 1", start);
            return;
        end
        if (lat > 0) begin
            repeat (lat) @(negedge clk);
            eng_done = 1'b1;
            eng_result = res;
            @(negedge clk);
            eng_done = 1'b0;
            eng_result = RW'($urandom);
        end
    endtask

    task automatic wait_out(output bit ok);
        int n = 0;
        while (!bif.out_valid && n < 100) begin @(negedge clk); n++; end
        ok = bif.out_valid;
    endtask

    task automatic pop_exp(input string name, output exp_t e);
        vectors++;
        if (sb.size() == 0) begin
            miscompares++;
            $display("FAIL %s: scoreboard empty, got 0 entries, required 1", name);
            e = '{default: '0};
        end else begin
            e = sb.pop_front();
        end
    endtask

    task automatic release_out();
        bif.out_ready = 1'b1;
        @(negedge clk);
        bif.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bif.in_ready, bif.out_valid, start, a_flat, b_flat, bif.out_result, bif.out_cycles, bif.out_error}
            !== {1'b1, 1'b0, 1'b0, {FW{1'b0}}, {FW{1'b0}}, {RW{1'b0}}, 8'd0, 1'b0}) begin
            miscompares++;
            $display("FAIL reset_values: in_ready=%0b out_valid=%0b start=%0b a=%h b=%h res=%0d cyc=%0d err=%0b, required 1 0 0 0 0 0 0 0",
                     bif.in_ready, bif.out_valid, start, a_flat, b_flat, bif.out_result, bif.out_cycles, bif.out_error);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_basic(input string name, input bit bubbles);
        logic [FW-1:0] a = 32'h04030201, b = 32'h08060402;
        int s0 = start_cnt;
        bit ok;
        exp_t e;
        push_exp(a, b, 32'd60, 8'd3, 1'b0);
        load_vec(a, b, bubbles);
        engine(3, dot(a, b));
        wait_out(ok);
        pop_exp(name, e);
        vectors += 4;
        if (!ok || {bif.out_result, bif.out_cycles, bif.out_error} !== {e.res, e.cyc, e.err}) begin
            miscompares++;
            $display("FAIL %s_result: valid=%0b res=%0d cyc=%0d err=%0b, required res=%0d cyc=%0d err=%0b",
                     name, ok, bif.out_result, bif.out_cycles, bif.out_error, e.res, e.cyc, e.err);
        end
        if ({a_flat, b_flat} !== {e.a, e.b}) begin
            miscompares++;
            $display("FAIL %s_flats: a=%h b=%h, required a=%h b=%h", name, a_flat, b_flat, e.a, e.b);
        end
        if (start_cnt !== s0 + 1) begin
            miscompares++;
            $display("FAIL %s_start_count: got %0d pulses, required 1", name, start_cnt - s0);
        end
        if (start_edge !== last_acc + 1) begin
            miscompares++;
            $display("FAIL %s_start_latency: got %0d edges after accept, required 1", name, start_edge - last_acc);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        logic [FW-1:0] a = 32'h0a0b0c0d, b = 32'h01020304;
        logic [FW-1:0] a2 = 32'h11223344, b2 = 32'h05060708;
        int acc0;
        bit ok;
        exp_t e;
        push_exp(a, b, dot(a, b), 8'd2, 1'b0);
        load_vec(a, b, 1'b0);
        engine(2, dot(a, b));
        wait_out(ok);
        pop_exp("bp", e);
        bif.in_valid = 1'b1;
        bif.in_data  = a2[N-1:0];
        acc0 = acc_cnt;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({bif.out_valid, bif.out_result, bif.out_cycles, bif.in_ready} !== {1'b1, e.res, e.cyc, 1'b0}) begin
                miscompares++;
                $display("FAIL bp_hold%0d: valid=%0b res=%0d cyc=%0d in_ready=%0b, required 1 %0d %0d 0",
                         i, bif.out_valid, bif.out_result, bif.out_cycles, bif.in_ready, e.res, e.cyc);
            end
        end
        vectors++;
        if (acc_cnt !== acc0) begin
            miscompares++;
            $display("FAIL bp_no_consume: got %0d accepts, required 0", acc_cnt - acc0);
        end
        push_exp(a2, b2, dot(a2, b2), 8'd4, 1'b0);
        release_out();
        vectors++;
        if ({bif.out_valid, bif.in_ready} !== 2'b01) begin
            miscompares++;
            $display("FAIL bp_release: out_valid=%0b in_ready=%0b, required 0 1", bif.out_valid, bif.in_ready);
        end
        @(negedge clk);
        vectors++;
        if (acc_cnt !== acc0 + 1) begin
            miscompares++;
            $display("FAIL bp_take_next: got %0d accepts, required 1", acc_cnt - acc0);
        end
        for (int i = 1; i < 2 * int'(LEN); i++)
            send_word((i < int'(LEN)) ? a2[i*N +: N] : b2[(i-int'(LEN))*N +: N], 0);
        engine(4, dot(a2, b2));
        wait_out(ok);
        pop_exp("bp_next", e);
        vectors++;
        if (!ok || {bif.out_result, bif.out_cycles, bif.out_error, a_flat, b_flat} !== {e.res, e.cyc, e.err, e.a, e.b}) begin
            miscompares++;
            $display("FAIL bp_next_result: res=%0d cyc=%0d err=%0b a=%h, required %0d %0d %0b %h",
                     bif.out_result, bif.out_cycles, bif.out_error, a_flat, e.res, e.cyc, e.err, e.a);
        end
        release_out();
    endtask

    task automatic test_timeout();
        logic [FW-1:0] a = 32'h01010101, b = 32'h02020202;
        bit ok;
        exp_t e;
        int lats[3] = '{0, 1, 16};
        for (int k = 0; k < 3; k++) begin
            if (lats[k] == 0) push_exp(a, b, '0, 8'(TIMEOUT), 1'b1);
            else              push_exp(a, b, dot(a, b), 8'(lats[k]), 1'b0);
            load_vec(a, b, 1'b0);
            engine(lats[k], dot(a, b));
            wait_out(ok);
            pop_exp("timeout", e);
            vectors++;
            if (!ok || {bif.out_result, bif.out_cycles, bif.out_error} !== {e.res, e.cyc, e.err}) begin
                miscompares++;
                $display("FAIL timeout_lat%0d: valid=%0b res=%0d cyc=%0d err=%0b, required %0d %0d %0b",
                         lats[k], ok, bif.out_result, bif.out_cycles, bif.out_error, e.res, e.cyc, e.err);
            end
            release_out();
        end
    endtask

    task automatic test_reset_mid_wait();
        logic [FW-1:0] a = 32'h09080706, b = 32'h03030303;
        int s0;
        load_vec(a, b, 1'b0);
        engine(0, '0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        vectors++;
        if ({bif.out_valid, start, a_flat, b_flat, bif.out_result, bif.out_cycles, bif.out_error, bif.in_ready}
            !== {1'b0, 1'b0, {FW{1'b0}}, {FW{1'b0}}, {RW{1'b0}}, 8'd0, 1'b0, 1'b1}) begin
            miscompares++;
            $display("FAIL async_reset: valid=%0b start=%0b a=%h b=%h res=%0d cyc=%0d err=%0b in_ready=%0b, required 0 0 0 0 0 0 0 1",
                     bif.out_valid, start, a_flat, b_flat, bif.out_result, bif.out_cycles, bif.out_error, bif.in_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt;
        eng_done = 1'b1;
        eng_result = 32'hdeadbeef;
        repeat (3) @(negedge clk);
        eng_done = 1'b0;
        @(negedge clk);
        vectors++;
        if ({bif.out_valid, bif.in_ready, bif.out_result} !== {1'b0, 1'b1, {RW{1'b0}}} || start_cnt !== s0) begin
            miscompares++;
            $display("FAIL stray_done: valid=%0b in_ready=%0b res=%h starts=%0d, required 0 1 0 0",
                     bif.out_valid, bif.in_ready, bif.out_result, start_cnt - s0);
        end
        test_basic("post_reset", 1'b0);
    endtask

    task automatic test_saturate();
        logic [FW-1:0] a = '1, b = '1;
        bit ok;
        exp_t e;
        push_exp(a, b, 32'd260100, 8'd5, 1'b0);
        load_vec(a, b, 1'b1);
        engine(5, dot(a, b));
        wait_out(ok);
        pop_exp("saturate", e);
        vectors++;
        if (!ok || {bif.out_result, bif.out_cycles, bif.out_error, a_flat, b_flat} !== {e.res, e.cyc, e.err, e.a, e.b}) begin
            miscompares++;
            $display("FAIL saturate: res=%0d cyc=%0d err=%0b a=%h b=%h, required %0d %0d %0b %h %h",
                     bif.out_result, bif.out_cycles, bif.out_error, a_flat, b_flat, e.res, e.cyc, e.err, e.a, e.b);
        end
        release_out();
    endtask

    initial begin
        bif.in_valid  = 1'b0;
        bif.in_data   = '0;
        bif.out_ready = 1'b0;
        eng_done      = 1'b0;
        eng_result    = '0;
        test_reset();
        test_basic("back_to_back", 1'b0);
        test_basic("bubbles", 1'b1);
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_saturate();
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d leftover entries, required 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/dot_product_loader.md
Name: dot_product_loader

Overview:
Operand-side front end for the dot-product engines (seq or par). Accepts element words serially over a valid/ready stream (a0..a[LEN-1], then b0..b[LEN-1]) and packs them into flat operand vectors. Issues a one-cycle start to the engine, waits for its done pulse, and returns the result plus the measured engine latency over a valid/ready output handshake. A timeout guards against an engine that never completes.

Parameters:
N, 8, element width in bits
LEN, 4, elements per vector
TIMEOUT, 16, max WAIT cycles before error; legal range 1..255

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  element word valid
in_ready  out  1  loader can accept an element
in_data  in  N  element word
a_flat  out  LEN*N  operand a; element i in bits [i*N +: N]
b_flat  out  LEN*N  operand b; same packing
start  out  1  one-cycle pulse to the engine
eng_done  in  1  engine completion pulse
eng_result  in  4*N  engine result, valid in the eng_done cycle
out_valid  out  1  result available
out_ready  in  1  consumer accepts the result
out_result  out  4*N  captured result
out_cycles  out  8  engine latency in cycles
out_error  out  1  timeout occurred

Behaviour:
- Reset (async, rst_n low): state=LOAD, idx=0, a_flat=0, b_flat=0, start=0, out_valid=0, out_result=0, out_cycles=0, out_error=0, wait counter=0. A reset mid-operation abandons the transaction. No start is issued after rst_n releases until a full 2*LEN-element load completes.
- The FSM has four states: LOAD, START, WAIT, OUTPUT. All outputs are registered except in_ready, which is 1 iff state==LOAD.
- LOAD:
  - Accept when in_valid & in_ready.
  - idx<LEN writes a[idx]; otherwise writes b[idx-LEN]. idx then increments.
  - Accepting idx==2*LEN-1 moves to START and sets idx=0.
  - in_data is ignored when in_valid=0. Bubbles are allowed.
- START: start=1 for exactly this one cycle. Wait counter cleared to 0. Next state is WAIT.
- WAIT:
  - If eng_done: capture eng_result into out_result; out_cycles=cnt+1; out_error=0; move to OUTPUT.
  - Else if cnt+1==TIMEOUT: out_result=0, out_cycles=TIMEOUT, out_error=1; move to OUTPUT.
  - Otherwise cnt increments.
  - eng_done and timeout in the same cycle: done wins.
- OUTPUT:
  - out_valid=1; out_result, out_cycles and out_error are held stable until out_ready.
  - On out_valid & out_ready: out_valid=0 next cycle and state returns to LOAD.
  - out_error is cleared at the next START.
- a_flat and b_flat are stable from START through OUTPUT, so the engine may sample them combinationally. They change only on LOAD accepts.
- eng_done outside WAIT is ignored.
- Latency from the 8th element accept to start: start is high the cycle after the accept.

Decomposition:
- Package dot_product_pkg holds: N and LEN defaults, TIMEOUT default, the state encoding (LOAD, START, WAIT, OUTPUT, 2 bits), and the cycle-count width constant (8).
- One sub-module is natural: dot_product_wait_timer. It is the WAIT counter: clear, enable, compare against TIMEOUT, and output the expired flag plus the count.

Test Plan:
- Feed 1,2,3,4,2,4,6,8 back-to-back, with a mock engine asserting eng_done and result 60 three cycles after start -> a_flat=0x04030201, b_flat=0x08060402, one start pulse, out_valid with out_result=60, out_cycles=3, out_error=0.
- Same data with in_valid bubbles of 0/1/3 cycles between words -> identical outputs; start asserted exactly once, the cycle after the 8th accept.
- out_ready held low 5 cycles in OUTPUT -> out_valid stays 1 and out_result stays 60; in_ready=0 and words presented meanwhile are not consumed. On out_ready=1 the FSM returns to LOAD and takes the next word.
- Mock engine never asserts eng_done -> after 16 WAIT cycles: out_valid=1, out_error=1, out_result=0, out_cycles=16. The next good transaction reports out_error=0.
- rst_n pulsed low during WAIT -> all outputs return to reset values asynchronously. A stray eng_done during the following LOAD is ignored. A fresh 8-element load then completes correctly.
- All elements 255 with an engine returning 260100 -> out_result=260100 held intact in the 32-bit field, with no truncation.
